nvme_irq_coalescer: RTL and testbench

//  Interrupt aggregation controller for the NVMe controller's single irq_req/irq_ack pair.

---
 rtl/nvme_irq_coalescer.sv | 142 ++++++++++++++
 tb/tb_nvme_irq_coalescer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_irq_coalescer.sv
// Interrupt coalescer: aggregates completion-queue postings into one irq_req per
// batch, fired when a count threshold or an aggregation-time limit is reached.
module nvme_irq_coalescer #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIME_W      = 8,
    parameter int unsigned TICK_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpl_valid,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_thr,
    input  logic [TIME_W-1:0] cfg_time,
    input  logic              irq_ack,
    output logic              irq_req,
    output logic [CNT_W-1:0]  pending_cnt,
    output logic [1:0]        fire_cause
);

    localparam int unsigned   PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_REQ
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [TIME_W-1:0]   timer_q, timer_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                irq_req_d;
    logic [1:0]          cause_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W:0]      thr_lim;
    logic                thr_hit;
    logic                time_hit;

    // Hit detection on the count as it will be after this cycle's completion
    always_comb begin
        cnt_inc  = (pending_cnt == '1) ? pending_cnt : pending_cnt + CNT_W'(1);
        cnt_next = cpl_valid ? cnt_inc : pending_cnt;
        thr_lim  = {1'b0, cfg_thr} + (CNT_W + 1)'(1);
        thr_hit  = ({1'b0, cnt_next} >= thr_lim) || !cfg_en;
        time_hit = (timer_q >= cfg_time);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_next;
        timer_d   = timer_q;
        presc_d   = presc_q;
        irq_req_d = irq_req;
        cause_d   = fire_cause;

        unique case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                presc_d   = '0;
                irq_req_d = 1'b0;
                cause_d   = 2'b00;
                if (cpl_valid) begin
                    // A first completion that already satisfies the threshold fires
                    // on this edge; the time limit is only judged once in ACCUM.
                    if (thr_hit) begin
                        state_d   = ST_REQ;
                        irq_req_d = 1'b1;
                        cause_d   = 2'b01;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end

            ST_ACCUM: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (timer_q != '1) begin
                        timer_d = timer_q + TIME_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (thr_hit || time_hit) begin
                    state_d   = ST_REQ;
                    irq_req_d = 1'b1;
                    cause_d   = {time_hit, thr_hit};
                end
            end

            ST_REQ: begin
                irq_req_d = 1'b1;
                if (irq_ack) begin
                    irq_req_d = 1'b0;
                    cause_d   = 2'b00;
                    timer_d   = '0;
                    presc_d   = '0;
                    if (cpl_valid) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                timer_d   = '0;
                presc_d   = '0;
                irq_req_d = 1'b0;
                cause_d   = 2'b00;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_cnt <= '0;
            timer_q     <= '0;
            presc_q     <= '0;
            irq_req     <= 1'b0;
            fire_cause  <= 2'b00;
        end else begin
            state_q     <= state_d;
            pending_cnt <= cnt_d;
            timer_q     <= timer_d;
            presc_q     <= presc_d;
            irq_req     <= irq_req_d;
            fire_cause  <= cause_d;
        end
    end

endmodule

// File: tb/tb_nvme_irq_coalescer.sv
// Directed bench for nvme_irq_coalescer: a table of per-cycle vectors plus
// hand-written sequences for timer, hold, saturation and reset corner cases.
module tb_nvme_irq_coalescer;

    logic       clk;
    logic       reset_n;
    logic       cpl_valid;
    logic       cfg_en;
    logic [7:0] cfg_thr;
    logic [7:0] cfg_time;
    logic       irq_ack;
    logic       irq_req;
    logic [7:0] pending_cnt;
    logic [1:0] fire_cause;

    int unsigned n_tests;
    int unsigned n_fail;

    nvme_irq_coalescer #(
        .CNT_W      (8),
        .TIME_W     (8),
        .TICK_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpl_valid  (cpl_valid),
        .cfg_en     (cfg_en),
        .cfg_thr    (cfg_thr),
        .cfg_time   (cfg_time),
        .irq_ack    (irq_ack),
        .irq_req    (irq_req),
        .pending_cnt(pending_cnt),
        .fire_cause (fire_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cpl;
        logic       en;
        logic [7:0] thr;
        logic [7:0] tim;
        logic       ack;
        logic       req;
        logic [7:0] cnt;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[33];

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int req, input int cnt, input int cause);
        check({tag, " irq_req"}, int'(irq_req), req);
        check({tag, " pending_cnt"}, int'(pending_cnt), cnt);
        check({tag, " fire_cause"}, int'(fire_cause), cause);
    endtask

    initial begin
        int fire_k;

        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        cpl_valid = 1'b0;
        cfg_en    = 1'b1;
        cfg_thr   = 8'd3;
        cfg_time  = 8'd255;
        irq_ack   = 1'b0;

        //                cpl en thr  tim  ack | req cnt cause
        vecs[0]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'd3,   8'd255, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b0, 8'd2, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'd3,   8'd255, 1'b0, 1'b0, 8'd2, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b0, 8'd3, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'd3,   8'd255, 1'b0, 1'b0, 8'd3, 2'd0};
        vecs[6]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b1, 8'd4, 2'd1};
        vecs[7]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b1, 8'd5, 2'd1};
        vecs[8]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b1, 8'd6, 2'd1};
        vecs[9]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b0, 1'b1, 8'd7, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 8'd3,   8'd255, 1'b1, 1'b0, 8'd0, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 8'd3,   8'd255, 1'b1, 1'b0, 8'd0, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 8'd1,   8'd255, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[13] = '{1'b1, 1'b1, 8'd1,   8'd255, 1'b0, 1'b1, 8'd2, 2'd1};
        vecs[14] = '{1'b1, 1'b1, 8'd1,   8'd255, 1'b1, 1'b0, 8'd1, 2'd0};
        vecs[15] = '{1'b0, 1'b1, 8'd1,   8'd255, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[16] = '{1'b1, 1'b1, 8'd1,   8'd255, 1'b0, 1'b1, 8'd2, 2'd1};
        vecs[17] = '{1'b0, 1'b1, 8'd1,   8'd255, 1'b1, 1'b0, 8'd0, 2'd0};
        vecs[18] = '{1'b1, 1'b1, 8'd1,   8'd255, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[19] = '{1'b1, 1'b1, 8'd1,   8'd255, 1'b1, 1'b1, 8'd2, 2'd1};
        vecs[20] = '{1'b0, 1'b1, 8'd255, 8'd255, 1'b0, 1'b1, 8'd2, 2'd1};
        vecs[21] = '{1'b0, 1'b1, 8'd255, 8'd255, 1'b1, 1'b0, 8'd0, 2'd0};
        vecs[22] = '{1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[23] = '{1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 8'd2, 2'd0};
        vecs[24] = '{1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 1'b0, 8'd3, 2'd0};
        vecs[25] = '{1'b0, 1'b1, 8'd1,   8'd255, 1'b0, 1'b1, 8'd3, 2'd1};
        vecs[26] = '{1'b0, 1'b1, 8'd1,   8'd255, 1'b1, 1'b0, 8'd0, 2'd0};
        vecs[27] = '{1'b1, 1'b1, 8'd1,   8'd0,   1'b0, 1'b0, 8'd1, 2'd0};
        vecs[28] = '{1'b1, 1'b1, 8'd1,   8'd0,   1'b0, 1'b1, 8'd2, 2'd3};
        vecs[29] = '{1'b0, 1'b1, 8'd1,   8'd0,   1'b1, 1'b0, 8'd0, 2'd0};
        vecs[30] = '{1'b1, 1'b1, 8'd15,  8'd0,   1'b0, 1'b0, 8'd1, 2'd0};
        vecs[31] = '{1'b0, 1'b1, 8'd15,  8'd0,   1'b0, 1'b1, 8'd1, 2'd2};
        vecs[32] = '{1'b0, 1'b1, 8'd15,  8'd0,   1'b1, 1'b0, 8'd0, 2'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_all("post_reset_idle", 0, 0, 0);

        // Table-driven sequence
        for (int i = 0; i < 33; i++) begin
            cpl_valid = vecs[i].cpl;
            cfg_en    = vecs[i].en;
            cfg_thr   = vecs[i].thr;
            cfg_time  = vecs[i].tim;
            irq_ack   = vecs[i].ack;
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].req), int'(vecs[i].cnt),
                      int'(vecs[i].cause));
        end
        cpl_valid = 1'b0;
        irq_ack   = 1'b0;

        // Timer fire: 4 cycles per tick, limit 2 ticks; a later completion must not restart it
        cfg_en    = 1'b1;
        cfg_thr   = 8'd15;
        cfg_time  = 8'd2;
        cpl_valid = 1'b1;
        tick();
        check_all("timer_start", 0, 1, 0);
        fire_k = -1;
        for (int k = 1; k <= 50; k++) begin
            cpl_valid = (k == 3);
            tick();
            if (irq_req) begin
                fire_k = k;
                break;
            end
        end
        cpl_valid = 1'b0;
        check("timer_fire_cycle", fire_k, 9);
        check_all("timer_fire", 1, 2, 2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check_all("timer_ack", 0, 0, 0);

        // Coalescing off: one completion fires at once, request held without ack
        cfg_en    = 1'b0;
        cfg_time  = 8'd255;
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        check_all("en0_fire", 1, 1, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("en0_hold%0d", k), int'(irq_req), 1);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check_all("en0_ack", 0, 0, 0);

        // Saturation: 300 completions, threshold unreachable
        cfg_en  = 1'b1;
        cfg_thr = 8'd255;
        for (int k = 1; k <= 300; k++) begin
            cpl_valid = 1'b1;
            tick();
            if (k == 255 || k == 256) begin
                check($sformatf("sat_cnt_at%0d", k), int'(pending_cnt), 255);
            end
        end
        cpl_valid = 1'b0;
        tick();
        check_all("sat_end", 0, 255, 0);

        // Reset mid-ACCUM with cnt=5
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all("sat_clear_reset", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cpl_valid = 1'b1;
            tick();
        end
        cpl_valid = 1'b0;
        check_all("accum_cnt5", 0, 5, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("reset_mid_accum", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) tick();
        check_all("post_reset_quiet", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
